simplez_core: RTL and testbench
===============================

# simplez_core

Parametrised, memory-decoupled Simplez CPU core: it implements the full eight-instruction Simplez ISA (ST, LD, ADD, BR, BZ, CLR, DEC, HALT) with configurable data and address widths. It talks to program/data memory through a single request/acknowledge port that tolerates any number of wait states. It is the successor to the fixed-width fetch-only sequencer and sits between the top-level board wrapper and the on-chip memory/peripheral decoder.

## Interface
- DATAW, 12, width of data bus, accumulator (AC) and instruction register (RI); must equal ADDRW+3
- ADDRW, 9, width of address bus, PC and operand field CD
- RESET_PC, 0, PC value loaded by reset
- CNTW, 16, width of retired-instruction counter
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDRW  transaction address
- mem_wdata  out  DATAW  write data (always AC)
- mem_rdata  in  DATAW  read data, sampled in ack cycle
- mem_ack  in  1  transaction completes at the rising edge where mem_req=1 and mem_ack=1
- halted  out  1  core stopped on HALT
- pc  out  ADDRW  current PC (debug)
- acc  out  DATAW  current AC (debug)
- instret  out  CNTW  retired-instruction count, wraps

## Operation
- Instruction format: CO = RI[DATAW-1:DATAW-3], CD = RI[ADDRW-1:0]. Opcodes: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
- FSM states: FETCH, EXEC, OPER, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ack: RI<=mem_rdata, PC<=PC+1 (mod 2^ADDRW), go to EXEC. Without ack: stay, all outputs held.
  - EXEC (1 cycle, no memory request): BR: PC<=CD. BZ: PC<=CD if AC==0, else unchanged. CLR: AC<=0. DEC: AC<=AC-1 (mod 2^DATAW, 0 -> all-ones). These four retire, go to FETCH. ST/LD/ADD: go to OPER. HALT: retire, go to HALT.
  - OPER: mem_req=1, mem_addr=CD, mem_we=1 for ST else 0, mem_wdata=AC. On ack: LD: AC<=mem_rdata; ADD: AC<=AC+mem_rdata (mod 2^DATAW, carry discarded); ST: no register change. Retire, go to FETCH.
  - HALT: mem_req=0, halted=1; remains until rst. PC holds address after the HALT.
- Retire: instret<=instret+1 at the retiring edge (once per instruction, HALT included).
- mem_req, mem_we are 0 in EXEC and HALT; mem_we is 0 whenever mem_req=0.
- Reset values (effective at the edge where rst=1, and outputs forced combinationally while rst=1): state=FETCH, PC=RESET_PC, AC=0, RI=0, instret=0, halted=0, mem_req=0, mem_we=0. An in-flight transaction is abandoned; mem_ack during rst is ignored.

## Timing
- Zero-wait memory (mem_ack tied 1): BR/BZ/CLR/DEC/HALT take 2 cycles; ST/LD/ADD take 3 cycles.
- With w wait cycles per transaction: 2+w and 3+2w respectively.
- While mem_req=1 and mem_ack=0, mem_addr, mem_we and mem_wdata are stable.
- After an ack, mem_req may stay high into the next cycle only if the new state also requests (OPER->FETCH); it then carries the new address.
- mem_ack while mem_req=0 is ignored.
- First fetch request appears in the first cycle with rst=0.

## Test plan
- Reset, zero-wait; mem[0]=0xA00 (CLR), mem[1]=0xE00 (HALT) -> halted=1 after 4 cycles, pc=2, acc=0, instret=2, mem_req=0 thereafter.
- mem[0]=0x220 (LD 0x20), mem[1]=0x421 (ADD 0x21), mem[2]=0x022 (ST 0x22), mem[3]=0xE00; mem[0x20]=0xFFF, mem[0x21]=0x002 -> write to 0x22 with mem_wdata=0x001, mem_we=1 for exactly one ack; acc=0x001, instret=4, halted after 11 cycles.
- Loop: mem[0]=0x220, mem[0x20]=3, mem[1]=0xC00 (DEC), mem[2]=0x804 (BZ 4), mem[3]=0x601 (BR 1), mem[4]=0xE00 -> acc=0, pc=5, instret=10; then CLR+DEC program gives acc=0xFFF.
- Wait states: mem_ack delayed 3 cycles on every request, rerun previous program -> identical final state; LD takes 9 cycles; mem_addr/mem_we/mem_wdata checked stable during every wait.
- PC wrap: mem[0]=0x7FF (BR 0x1FF), mem[0x1FF]=0xA00 -> after fetching 0x1FF, pc=0x000, next fetch address 0x000.
- rst asserted for 1 cycle while OPER waits for ack -> mem_req=0 in that cycle, next cycle fetch from 0x000, acc=0, instret=0, halted=0; also rst while halted -> execution restarts.

Source files
------------

// File: rtl/simplez_core.sv
// simplez_core: parametrised Simplez CPU with a single request/acknowledge
// memory port. It runs the eight-instruction Simplez ISA through a
// FETCH -> EXEC -> (OPER) -> FETCH loop, and it stops in HALT until reset.
// The memory port accepts any number of wait states.
//
// DATAW must equal ADDRW+3. The top three bits of an instruction hold the
// opcode and the remaining ADDRW bits hold the operand address.

module simplez_core #(
    parameter int DATAW    = 12,
    parameter int ADDRW    = 9,
    parameter int RESET_PC = 0,
    parameter int CNTW     = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             halted,
    output logic [ADDRW-1:0] pc,
    output logic [DATAW-1:0] acc,
    output logic [CNTW-1:0]  instret
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_OPER  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ST   = 3'd0,
        OP_LD   = 3'd1,
        OP_ADD  = 3'd2,
        OP_BR   = 3'd3,
        OP_BZ   = 3'd4,
        OP_CLR  = 3'd5,
        OP_DEC  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    localparam logic [ADDRW-1:0] PC_RST = ADDRW'(RESET_PC);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [ADDRW-1:0] pc_q,      pc_d;
    logic [DATAW-1:0] ac_q,      ac_d;
    logic [DATAW-1:0] ri_q,      ri_d;
    logic [CNTW-1:0]  instret_q, instret_d;

    // Memory port values before the reset override.
    logic             req_c;
    logic             we_c;
    logic [ADDRW-1:0] addr_c;

    // Fields of the current instruction.
    opcode_t          op;
    logic [ADDRW-1:0] cd;
    logic             ac_zero;

    assign op      = opcode_t'(ri_q[DATAW-1 -: 3]);
    assign cd      = ri_q[ADDRW-1:0];
    assign ac_zero = (ac_q == '0);

    // State and datapath registers; synchronous reset abandons any transaction.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_RST;
            ac_q      <= '0;
            ri_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ac_q      <= ac_d;
            ri_q      <= ri_d;
            instret_q <= instret_d;
        end
    end

    // Next-state, datapath updates and memory-port drive for each FSM state.
    // NOTE: every signal gets its hold or idle value first, so a path that
    // does not assign it cannot infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ac_d      = ac_q;
        ri_d      = ri_q;
        instret_d = instret_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = pc_q;

        unique case (state_q)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem_ack) begin
                    ri_d    = mem_rdata;
                    pc_d    = pc_q + ADDRW'(1);
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                unique case (op)
                    OP_BR: begin
                        pc_d      = cd;
                        instret_d = instret_q + CNTW'(1);
                        state_d   = S_FETCH;
                    end
                    OP_BZ: begin
                        if (ac_zero) begin
                            pc_d = cd;
                        end
                        instret_d = instret_q + CNTW'(1);
                        state_d   = S_FETCH;
                    end
                    OP_CLR: begin
                        ac_d      = '0;
                        instret_d = instret_q + CNTW'(1);
                        state_d   = S_FETCH;
                    end
                    OP_DEC: begin
                        ac_d      = ac_q - DATAW'(1);
                        instret_d = instret_q + CNTW'(1);
                        state_d   = S_FETCH;
                    end
                    OP_HALT: begin
                        instret_d = instret_q + CNTW'(1);
                        state_d   = S_HALT;
                    end
                    OP_ST, OP_LD, OP_ADD: begin
                        state_d = S_OPER;
                    end
                endcase
            end

            S_OPER: begin
                req_c  = 1'b1;
                addr_c = cd;
                we_c   = (op == OP_ST);
                if (mem_ack) begin
                    if (op == OP_LD) begin
                        ac_d = mem_rdata;
                    end else if (op == OP_ADD) begin
                        ac_d = ac_q + mem_rdata;
                    end
                    instret_d = instret_q + CNTW'(1);
                    state_d   = S_FETCH;
                end
            end

            S_HALT: begin
                // Stays here until reset, with no memory traffic.
            end
        endcase
    end

    // While rst is high, the outputs show reset values immediately.
    assign mem_req   = req_c & ~rst;
    assign mem_we    = we_c & ~rst;
    assign mem_addr  = addr_c;
    assign mem_wdata = ac_q;
    assign halted    = (state_q == S_HALT) & ~rst;
    assign pc        = rst ? PC_RST : pc_q;
    assign acc       = rst ? '0 : ac_q;
    assign instret   = rst ? '0 : instret_q;

endmodule

// File: tb/tb_simplez_core.sv
// Self-checking bench for simplez_core. A behavioural memory responder adds
// a configurable number of wait states. An ISA-level interpreter predicts
// the architectural state, the memory image and the cycle count of each
// instruction.

module tb_simplez_core;

    localparam int DATAW = 12;
    localparam int ADDRW = 9;
    localparam int CNTW  = 16;
    localparam int MEMSZ = 1 << ADDRW;

    logic             clk;
    logic             rst;
    logic             mem_req;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [DATAW-1:0] mem_wdata;
    logic [DATAW-1:0] mem_rdata;
    logic             mem_ack;
    logic             halted;
    logic [ADDRW-1:0] pc;
    logic [DATAW-1:0] acc;
    logic [CNTW-1:0]  instret;

    simplez_core #(
        .DATAW(DATAW), .ADDRW(ADDRW), .RESET_PC(0), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .pc(pc), .acc(acc), .instret(instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench memory and responder state.
    logic [DATAW-1:0] mem [MEMSZ];
    assign mem_rdata = mem[mem_addr];

    int               pass_cnt = 0;
    int               total_cnt = 0;
    int               wait_cfg = 0;
    int               wr_cnt = 0;
    logic [ADDRW-1:0] wr_addr;
    logic [DATAW-1:0] wr_data;

    int               r_wcnt = 0;
    bit               r_pend = 1'b0;
    logic [ADDRW-1:0] r_addr;
    logic             r_we;
    logic [DATAW-1:0] r_wdata;

    // Responder: decides ack mid-cycle, commits writes, checks port stability.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req) begin
                if (r_pend) begin
                    total_cnt++;
                    if (mem_addr !== r_addr || mem_we !== r_we || mem_wdata !== r_wdata)
                        $display("FAIL wait_stable: addr=%h we=%b wdata=%h, held addr=%h we=%b wdata=%h",
                                 mem_addr, mem_we, mem_wdata, r_addr, r_we, r_wdata);
                    else
                        pass_cnt++;
                end
                if (r_wcnt >= wait_cfg) begin
                    mem_ack = 1'b1;
                    r_wcnt  = 0;
                    r_pend  = 1'b0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wr_cnt++;
                        wr_addr = mem_addr;
                        wr_data = mem_wdata;
                    end
                end else begin
                    mem_ack = 1'b0;
                    r_wcnt++;
                    r_pend  = 1'b1;
                    r_addr  = mem_addr;
                    r_we    = mem_we;
                    r_wdata = mem_wdata;
                end
            end else begin
                total_cnt++;
                if (mem_we !== 1'b0)
                    $display("FAIL we_without_req: mem_we=%b, required 0", mem_we);
                else if (r_pend && !rst)
                    $display("FAIL req_dropped: mem_req=0 during wait, required 1");
                else
                    pass_cnt++;
                // The core must ignore acks while idle or in reset.
                mem_ack = (wait_cfg == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                r_wcnt  = 0;
                r_pend  = 1'b0;
            end
        end
    end

    // ISA-level reference model.
    logic [DATAW-1:0] exp_mem [MEMSZ];
    int               exp_lat[$];
    logic [ADDRW-1:0] exp_pc;
    logic [DATAW-1:0] exp_acc;
    int               exp_n;
    bit               exp_halt;

    task automatic model_run(input int w, input int max_inst);
        logic [DATAW-1:0] ir;
        logic [ADDRW-1:0] a;
        exp_mem  = mem;
        exp_pc   = '0;
        exp_acc  = '0;
        exp_n    = 0;
        exp_halt = 1'b0;
        exp_lat.delete();
        while (!exp_halt && exp_n < max_inst) begin
            ir     = exp_mem[exp_pc];
            a      = ir[ADDRW-1:0];
            exp_pc = exp_pc + ADDRW'(1);
            case (ir[DATAW-1:DATAW-3])
                3'd0: begin exp_mem[a] = exp_acc;            exp_lat.push_back(3 + 2 * w); end
                3'd1: begin exp_acc = exp_mem[a];            exp_lat.push_back(3 + 2 * w); end
                3'd2: begin exp_acc = exp_acc + exp_mem[a];  exp_lat.push_back(3 + 2 * w); end
                3'd3: begin exp_pc = a;                      exp_lat.push_back(2 + w); end
                3'd4: begin if (exp_acc == 0) exp_pc = a;    exp_lat.push_back(2 + w); end
                3'd5: begin exp_acc = '0;                    exp_lat.push_back(2 + w); end
                3'd6: begin exp_acc = exp_acc - DATAW'(1);   exp_lat.push_back(2 + w); end
                default: begin exp_halt = 1'b1;              exp_lat.push_back(2 + w); end
            endcase
            exp_n++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Runs the program in mem and compares it against the model.
    task automatic run_prog(input string name, input int w, input int max_inst);
        int cyc, prev, idx, budget, bad;
        logic [CNTW-1:0] last;
        model_run(w, max_inst);
        wait_cfg = w;
        wr_cnt   = 0;
        apply_reset();
        budget = 20;
        foreach (exp_lat[i]) budget += exp_lat[i];
        cyc = 0; prev = 0; idx = 0; last = '0;
        while (int'(instret) != exp_n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (instret != last) begin
                total_cnt++;
                if (idx < exp_lat.size() && cyc - prev == exp_lat[idx])
                    pass_cnt++;
                else
                    $display("FAIL %s latency[%0d]: took %0d cycles, required %0d",
                             name, idx, cyc - prev, (idx < exp_lat.size()) ? exp_lat[idx] : -1);
                prev = cyc; idx++; last = instret;
            end
        end
        total_cnt++;
        if (int'(instret) != exp_n) $display("FAIL %s instret: got %0d, required %0d (cycle budget %0d)", name, instret, exp_n, budget);
        else pass_cnt++;
        total_cnt++;
        if (halted !== exp_halt) $display("FAIL %s halted: got %b, required %b", name, halted, exp_halt);
        else pass_cnt++;
        total_cnt++;
        if (pc !== exp_pc) $display("FAIL %s pc: got %h, required %h", name, pc, exp_pc);
        else pass_cnt++;
        total_cnt++;
        if (acc !== exp_acc) $display("FAIL %s acc: got %h, required %h", name, acc, exp_acc);
        else pass_cnt++;
        total_cnt++;
        if (exp_halt ? (mem_req !== 1'b0) : (mem_req !== 1'b1 || mem_addr !== exp_pc))
            $display("FAIL %s port_after: req=%b addr=%h, required req=%b addr=%h",
                     name, mem_req, mem_addr, !exp_halt, exp_pc);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < MEMSZ; i++) if (mem[i] !== exp_mem[i]) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL %s memory: %0d words differ, required 0", name, bad);
        else pass_cnt++;
    endtask

    task automatic load_ld_add_st();
        clear_mem();
        mem[0] = 12'h220; mem[1] = 12'h421; mem[2] = 12'h022; mem[3] = 12'hE00;
        mem[9'h20] = 12'hFFF; mem[9'h21] = 12'h002;
    endtask

    task automatic load_loop();
        clear_mem();
        mem[0] = 12'h220; mem[1] = 12'hC00; mem[2] = 12'h804; mem[3] = 12'h601;
        mem[4] = 12'hE00; mem[9'h20] = 12'd3;
    endtask

    task automatic test_reset();
        wait_cfg = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_ctrl: req=%b we=%b halted=%b, required 0 0 0", mem_req, mem_we, halted);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (pc !== 9'h000 || acc !== 12'h000 || instret !== 16'd0)
            $display("FAIL reset_regs: pc=%h acc=%h instret=%0d, required 000 000 0", pc, acc, instret);
        else pass_cnt++;
        rst = 1'b0; #1;
        total_cnt++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'h000)
            $display("FAIL first_fetch: req=%b we=%b addr=%h, required 1 0 000", mem_req, mem_we, mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_clr_halt();
        clear_mem();
        mem[0] = 12'hA00; mem[1] = 12'hE00;
        run_prog("clr_halt", 0, 100);
        total_cnt++;
        if (pc !== 9'h002 || instret !== 16'd2 || acc !== 12'h000 || halted !== 1'b1)
            $display("FAIL clr_halt_const: pc=%h instret=%0d acc=%h halted=%b, required 002 2 000 1", pc, instret, acc, halted);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (mem_req !== 1'b0) $display("FAIL halt_idle[%0d]: mem_req=%b, required 0", i, mem_req);
            else pass_cnt++;
        end
    endtask

    task automatic test_ld_add_st(input int w);
        load_ld_add_st();
        run_prog("ld_add_st", w, 100);
        total_cnt++;
        if (wr_cnt != 1 || wr_addr !== 9'h022 || wr_data !== 12'h001 || acc !== 12'h001)
            $display("FAIL st_write: writes=%0d addr=%h data=%h acc=%h, required 1 022 001 001", wr_cnt, wr_addr, wr_data, acc);
        else pass_cnt++;
    endtask

    task automatic test_loop(input int w);
        load_loop();
        run_prog("loop", w, 100);
        total_cnt++;
        if (acc !== 12'h000 || pc !== 9'h005 || instret !== 16'd10)
            $display("FAIL loop_const: acc=%h pc=%h instret=%0d, required 000 005 10", acc, pc, instret);
        else pass_cnt++;
    endtask

    task automatic test_dec_wrap();
        clear_mem();
        mem[0] = 12'hA00; mem[1] = 12'hC00; mem[2] = 12'hE00;
        run_prog("clr_dec", 0, 100);
        total_cnt++;
        if (acc !== 12'hFFF) $display("FAIL dec_wrap: acc=%h, required fff", acc);
        else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem[0] = 12'h7FF; mem[9'h1FF] = 12'hA00;
        run_prog("pc_wrap", 0, 2);
        total_cnt++;
        if (pc !== 9'h000 || mem_addr !== 9'h000 || mem_req !== 1'b1)
            $display("FAIL pc_wrap: pc=%h addr=%h req=%b, required 000 000 1", pc, mem_addr, mem_req);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_oper();
        int cyc;
        load_ld_add_st();
        wait_cfg = 5;
        apply_reset();
        cyc = 0;
        while (!(mem_req && mem_addr == 9'h021) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (!(mem_req === 1'b1 && mem_addr === 9'h021 && acc === 12'hFFF))
            $display("FAIL oper_reach: req=%b addr=%h acc=%h, required 1 021 fff", mem_req, mem_addr, acc);
        else pass_cnt++;
        rst = 1'b1; #1;
        total_cnt++;
        if (mem_req !== 1'b0 || halted !== 1'b0)
            $display("FAIL oper_rst_req: req=%b halted=%b, required 0 0", mem_req, halted);
        else pass_cnt++;
        @(posedge clk); #1 rst = 1'b0; #1;
        total_cnt++;
        if (pc !== 9'h000 || acc !== 12'h000 || instret !== 16'd0 || halted !== 1'b0 ||
            mem_req !== 1'b1 || mem_addr !== 9'h000)
            $display("FAIL oper_rst_after: pc=%h acc=%h instret=%0d halted=%b req=%b addr=%h, required 000 000 0 0 1 000",
                     pc, acc, instret, halted, mem_req, mem_addr);
        else pass_cnt++;
        load_ld_add_st();
        run_prog("after_oper_rst", 5, 100);
    endtask

    task automatic test_reset_when_halted();
        int cyc;
        clear_mem();
        mem[0] = 12'hA00; mem[1] = 12'hE00;
        run_prog("pre_halt", 0, 100);
        @(posedge clk); #1 rst = 1'b1; #1;
        total_cnt++;
        if (halted !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL halt_rst: halted=%b req=%b, required 0 0", halted, mem_req);
        else pass_cnt++;
        @(posedge clk); #1 rst = 1'b0; #1;
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 9'h000 || halted !== 1'b0)
            $display("FAIL halt_restart: req=%b addr=%h halted=%b, required 1 000 0", mem_req, mem_addr, halted);
        else pass_cnt++;
        cyc = 0;
        while (!halted && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (halted !== 1'b1 || instret !== 16'd2 || cyc != 4)
            $display("FAIL halt_rerun: halted=%b instret=%0d cycles=%0d, required 1 2 4", halted, instret, cyc);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] = DATAW'($urandom);
            run_prog($sformatf("random%0d", p), $urandom_range(0, 2), 30);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_clr_halt();
        test_ld_add_st(0);
        test_loop(0);
        test_dec_wrap();
        test_loop(3);
        test_ld_add_st(2);
        test_pc_wrap();
        test_reset_in_oper();
        test_reset_when_halted();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
